// File: rtl/nibble_serial_adder_ctrl.sv
// Serial W-bit add/subtract sequencer built on one shared 4-bit ripple-carry adder.
// Handles one nibble per clock, LSB nibble first, with valid/ready handshakes on input and output.

module bit_adder (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_c,
   output logic [3:0] o_s,
   output logic       o_c
);
   logic [4:0] w_c;

   always_comb begin
      w_c    = '0;
      o_s    = '0;
      w_c[0] = i_c;
      for (int unsigned i = 0; i < 4; i++) begin
         o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
         w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
      end
      o_c = w_c[4];
   end
endmodule

module nibble_serial_adder_ctrl #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] op_a,
   input  logic [4*NIBBLES-1:0] op_b,
   input  logic                 sub,
   input  logic                 carry_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic                 ovf,
   output logic                 busy
);
   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    r_state;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_sum;
   logic          r_carry;
   logic [IW-1:0] r_idx;

   logic [3:0]    w_nib_a;
   logic [3:0]    w_nib_b;
   logic [3:0]    w_nib_sum;
   logic          w_nib_cout;
   logic [IW+1:0] w_base;

   assign w_base  = {r_idx, 2'b00};
   assign w_nib_a = r_a[w_base +: 4];
   assign w_nib_b = r_b[w_base +: 4];

   bit_adder u_bit_adder (
      .i_a (w_nib_a),
      .i_b (w_nib_b),
      .i_c (r_carry),
      .o_s (w_nib_sum),
      .o_c (w_nib_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  // Subtraction is A + ~B + 1, so the inverted operand and the seed carry are latched here.
                  r_a     <= op_a;
                  r_b     <= sub ? ~op_b : op_b;
                  r_carry <= sub ? 1'b1 : carry_in;
                  r_idx   <= '0;
                  r_sum   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_sum[w_base +: 4] <= w_nib_sum;
               r_carry            <= w_nib_cout;
               if (r_idx == LAST) begin
                  r_state <= S_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
   assign sum       = r_sum;
   assign cout      = out_valid & r_carry;
   assign ovf       = out_valid & (r_a[W-1] == r_b[W-1]) & (r_sum[W-1] != r_a[W-1]);
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that performs 4·NIBBLES-bit add/subtract operations on one internal 4-bit ripple-carry adder (`bit_adder`), one nibble per clock, LSB nibble first. The carry is chained through a register between nibbles. Operands enter through a valid/ready handshake and results leave through one. The block sits between a requesting datapath and the shared 4-bit adder and trades latency for area.

## Interface
- NIBBLES, default 4: operand width W = 4·NIBBLES bits; legal range 1..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  block can accept an operation.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- sub  input  1  0 = A+B+carry_in, 1 = A−B.
- carry_in  input  1  carry seed for add; ignored when sub = 1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result; meaningful only while out_valid = 1.
- cout  output  1  carry out of the MSB nibble (subtract: 1 = no borrow).
- ovf  output  1  two's-complement overflow.
- busy  output  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture a_r = op_a and b_r = sub ? ~op_b : op_b.
  - Seed carry_r = sub ? 1 : carry_in, set idx = 0, clear sum, go to RUN.
- RUN:
  - The adder inputs are a_r[4·idx+:4], b_r[4·idx+:4] and carry_r.
  - On each edge, sum[4·idx+:4] ← adder sum, carry_r ← adder cout, idx ← idx+1.
  - After the nibble at idx = NIBBLES−1 is captured, go to DONE.
- DONE:
  - out_valid = 1. cout = carry_r.
  - ovf = (a_r[W−1] == b_r[W−1]) & (sum[W−1] != a_r[W−1]).
  - On out_ready, go to IDLE.
- in_ready = 0 in RUN and DONE. in_valid is ignored there, and operands are not re-sampled.
- sum, cout and ovf are held stable for the whole time out_valid = 1.
- idx width is clog2(NIBBLES), minimum 1. idx never wraps past NIBBLES−1.
- Arithmetic is modulo 2^W. No saturation.

## Timing
- Reset values: state = IDLE, in_ready = 1 (follows IDLE), out_valid = 0, busy = 0, sum = 0, cout = 0, ovf = 0, carry_r = 0, idx = 0.
- Latency: an operation accepted on edge k raises out_valid after edge k+NIBBLES. That is 4 cycles for the default.
- Throughput: at most one operation per NIBBLES+2 cycles (RUN ×NIBBLES, DONE ≥1, IDLE 1). There is no accept in the same cycle as a result handshake.
- NIBBLES = 1: RUN lasts one cycle. Behaviour is otherwise identical.
- Backpressure: DONE is held indefinitely while out_ready = 0. out_ready while not in DONE has no effect.
- in_valid does not need to be held after acceptance. Changes to op_a, op_b or sub after acceptance do not affect the result.
- Asynchronous reset at any point (including mid-RUN or in DONE) returns immediately to the reset values. The in-flight operation is dropped with no partial out_valid. The first operation after reset deassertion runs normally.
- The adder path is combinational within one cycle. No multicycle constraints.

## Test plan
- Reset: assert rst_n = 0 mid-clock -> all outputs at reset values with no clock edge needed; in_ready = 1 after release.
- Add, default NIBBLES: 0x1234 + 0x0FCD, carry_in = 0 -> sum = 0x2201, cout = 0, ovf = 0, out_valid exactly 4 cycles after accept edge.
- Full carry ripple across nibbles:
  - 0xFFFF + 0x0001 -> sum 0x0000, cout 1, ovf 0.
  - 0xFFFF + 0x0000 with carry_in = 1 -> same result.
  - 0x7FFF + 0x0001 -> sum 0x8000, ovf 1.
- Subtract:
  - 0x0005 − 0x0007 -> sum 0xFFFE, cout 0, ovf 0.
  - 0x8000 − 0x0001 -> sum 0x7FFF, cout 1, ovf 1.
  - carry_in = 1 during subtract does not change the result.
- Backpressure: hold out_ready = 0 for 10 cycles while toggling in_valid and op_a -> out_valid, sum, cout and ovf stay constant, in_ready stays 0. Raise out_ready -> IDLE next cycle, then the next operation is accepted.
- Reset mid-RUN: assert rst_n after 2 nibbles of 0xAAAA + 0x5555 -> out_valid never rises, sum = 0. Then 0x0001 + 0x0001 -> sum 0x0002 with normal latency.
